// File: rtl/gshare_branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gshare_branch_predictor_pkg
// Purpose  : Shared constants, counter helpers and BTB entry type for the
//            gshare next-PC predictor.
// Revision : 1.0 - initial release
// ============================================================================
package gshare_branch_predictor_pkg;

  // PHT indexing selections
  localparam int C_HASH_BIMODAL = 0;
  localparam int C_HASH_GSHARE  = 1;

  // Reset value of a PHT counter: MSB clear, all lower bits set (weakly not-taken)
  function automatic int ctr_init_value(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

  // Saturation ceiling of a PHT counter
  function automatic int ctr_max_value(input int ctr_bits);
    return (1 << ctr_bits) - 1;
  endfunction

  // Control flags of one BTB entry; tag and target live in parallel arrays
  // because their widths follow the predictor parameters.
  typedef struct packed {
    logic valid;
    logic is_cond;
  } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/gshare_branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : gshare_branch_predictor_if
// Purpose  : Fetch-lookup, execute-resolve and performance signals between
//            the pipeline (master) and the predictor (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface gshare_branch_predictor_if #(
  parameter int XLEN      = 32,
  parameter int BHR_BITS  = 5,
  parameter int PERF_BITS = 32
);
  // IF-stage lookup
  logic                 if_stall;
  logic [XLEN-1:0]      if_pc;
  logic [XLEN-1:0]      if_next_pc;
  logic                 if_pred_taken;
  logic [BHR_BITS-1:0]  if_bhr;
  // EX-stage resolve
  logic                 ex_valid;
  logic [XLEN-1:0]      ex_pc;
  logic                 ex_is_branch;
  logic                 ex_is_jump;
  logic                 ex_taken;
  logic [XLEN-1:0]      ex_target;
  logic [XLEN-1:0]      ex_pred_next_pc;
  logic [BHR_BITS-1:0]  ex_bhr;
  logic                 flush;
  logic [XLEN-1:0]      redirect_pc;
  // Performance counters
  logic [PERF_BITS-1:0] perf_lookups;
  logic [PERF_BITS-1:0] perf_mispredicts;

  modport master (
    output if_stall, if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jump,
           ex_taken, ex_target, ex_pred_next_pc, ex_bhr,
    input  if_next_pc, if_pred_taken, if_bhr, flush, redirect_pc,
           perf_lookups, perf_mispredicts
  );

  modport slave (
    input  if_stall, if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jump,
           ex_taken, ex_target, ex_pred_next_pc, ex_bhr,
    output if_next_pc, if_pred_taken, if_bhr, flush, redirect_pc,
           perf_lookups, perf_mispredicts
  );
endinterface
`default_nettype wire

// File: rtl/gshare_branch_predictor_sat_counter_table.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter_table
// Purpose  : Pattern history table of saturating direction counters with one
//            combinational read port and one synchronous update port.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter_table
  import gshare_branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int CTR_BITS   = 2
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                       rd_taken_o,
  input  wire logic                  upd_en_i,
  input  wire logic [INDEX_BITS-1:0] upd_idx_i,
  input  wire logic                  upd_taken_i
);
  localparam int                  ENTRIES  = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init_value(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_max_value(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] w_upd_cur;
  logic [CTR_BITS-1:0] upd_d;

  // Prediction is the counter MSB; reads see pre-update contents
  assign rd_taken_o = ctr_q[rd_idx_i][CTR_BITS-1];

  // Saturating step of the entry being trained (no wrap at either end)
  always_comb begin
    w_upd_cur = ctr_q[upd_idx_i];
    upd_d     = w_upd_cur;
    if (upd_taken_i) begin
      if (w_upd_cur != CTR_MAX) upd_d = w_upd_cur + CTR_ONE;
    end else begin
      if (w_upd_cur != CTR_ZERO) upd_d = w_upd_cur - CTR_ONE;
    end
  end

  // Counter storage: reset to weakly not-taken, else write the trained entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= upd_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : gshare_branch_predictor
// Purpose  : Next-PC predictor: BTB + PHT lookup in IF, training, mispredict
//            detection and speculative history recovery from EX.
// Revision : 1.0 - initial release
// ============================================================================
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 5,
  parameter int BHR_BITS   = 5,
  parameter int CTR_BITS   = 2,
  parameter int HASH_MODE  = 1,
  parameter int PERF_BITS  = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  gshare_branch_predictor_if.slave bus
);
  localparam int                   ENTRIES  = 2 ** INDEX_BITS;
  localparam int                   TAG_BITS = XLEN - INDEX_BITS - 2;
  localparam logic [PERF_BITS-1:0] PERF_MAX = {PERF_BITS{1'b1}};
  localparam logic [PERF_BITS-1:0] PERF_ONE = PERF_BITS'(1);
  localparam logic [XLEN-1:0]      PC_STEP  = XLEN'(4);

  btb_entry_t           btb_meta_q   [ENTRIES];
  logic [TAG_BITS-1:0]  btb_tag_q    [ENTRIES];
  logic [XLEN-1:0]      btb_target_q [ENTRIES];
  logic [BHR_BITS-1:0]  bhr_q, bhr_d;
  logic [PERF_BITS-1:0] perf_lookups_q, perf_lookups_d;
  logic [PERF_BITS-1:0] perf_mispredicts_q, perf_mispredicts_d;

  logic [INDEX_BITS-1:0] w_if_idx, w_ex_idx, w_if_pht_idx, w_ex_pht_idx;
  logic [TAG_BITS-1:0]   w_if_tag, w_ex_tag;
  logic                  w_hit, w_if_cond, w_pht_taken, w_pred_taken;
  logic                  w_ex_cf, w_ex_redirect, w_train, w_flush;
  logic [XLEN-1:0]       w_actual;

  assign w_if_idx = bus.if_pc[INDEX_BITS+1:2];
  assign w_if_tag = bus.if_pc[XLEN-1:INDEX_BITS+2];
  assign w_ex_idx = bus.ex_pc[INDEX_BITS+1:2];
  assign w_ex_tag = bus.ex_pc[XLEN-1:INDEX_BITS+2];

  // PHT index: plain PC bits, or PC bits folded with the history snapshot
  generate
    if (HASH_MODE == C_HASH_GSHARE) begin : g_gshare
      assign w_if_pht_idx = w_if_idx ^ INDEX_BITS'(bhr_q);
      assign w_ex_pht_idx = w_ex_idx ^ INDEX_BITS'(bus.ex_bhr);
    end else begin : g_bimodal
      assign w_if_pht_idx = w_if_idx;
      assign w_ex_pht_idx = w_ex_idx;
    end
  endgenerate

  sat_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS)
  ) u_pht (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (w_if_pht_idx),
    .rd_taken_o  (w_pht_taken),
    .upd_en_i    (w_train && bus.ex_is_branch),
    .upd_idx_i   (w_ex_pht_idx),
    .upd_taken_i (bus.ex_taken)
  );

  // Lookup: unconditional entries always redirect, conditional ones ask the PHT
  assign w_hit         = btb_meta_q[w_if_idx].valid && (btb_tag_q[w_if_idx] == w_if_tag);
  assign w_if_cond     = btb_meta_q[w_if_idx].is_cond;
  assign w_pred_taken  = w_hit && (!w_if_cond || w_pht_taken);
  assign bus.if_pred_taken = w_pred_taken;
  assign bus.if_next_pc    = w_pred_taken ? btb_target_q[w_if_idx] : bus.if_pc + PC_STEP;
  assign bus.if_bhr        = bhr_q;

  // Resolve: compare the real successor against what fetch assumed
  assign w_ex_cf         = bus.ex_is_branch || bus.ex_is_jump;
  assign w_ex_redirect   = bus.ex_is_jump || (bus.ex_is_branch && bus.ex_taken);
  assign w_actual        = w_ex_redirect ? bus.ex_target : bus.ex_pc + PC_STEP;
  assign w_train         = bus.ex_valid && w_ex_cf;
  assign w_flush         = w_train && (w_actual != bus.ex_pred_next_pc);
  assign bus.flush       = w_flush;
  assign bus.redirect_pc = w_actual;

  // BTB flags: invalidate everything on reset, allocate on taken control flow
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) btb_meta_q[i] <= '0;
    end else if (w_train && w_ex_redirect) begin
      btb_meta_q[w_ex_idx].valid   <= 1'b1;
      btb_meta_q[w_ex_idx].is_cond <= bus.ex_is_branch;
    end
  end

  // BTB payload: only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (reset && w_train && w_ex_redirect) begin
      btb_tag_q[w_ex_idx]    <= w_ex_tag;
      btb_target_q[w_ex_idx] <= bus.ex_target;
    end
  end

  // History: recovery from EX outranks the speculative shift from IF
  always_comb begin
    bhr_d = bhr_q;
    if (w_flush) begin
      bhr_d = bus.ex_is_branch ? {bus.ex_bhr[BHR_BITS-2:0], bus.ex_taken} : bus.ex_bhr;
    end else if (!bus.if_stall && w_hit && w_if_cond) begin
      bhr_d = {bhr_q[BHR_BITS-2:0], w_pred_taken};
    end
  end

  // Performance counters saturate at all-ones
  always_comb begin
    perf_lookups_d     = perf_lookups_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (!bus.if_stall && (perf_lookups_q != PERF_MAX))
      perf_lookups_d = perf_lookups_q + PERF_ONE;
    if (w_flush && (perf_mispredicts_q != PERF_MAX))
      perf_mispredicts_d = perf_mispredicts_q + PERF_ONE;
  end

  // History and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      bhr_q              <= '0;
      perf_lookups_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      bhr_q              <= bhr_d;
      perf_lookups_q     <= perf_lookups_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign bus.perf_lookups     = perf_lookups_q;
  assign bus.perf_mispredicts = perf_mispredicts_q;

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_branch_predictor
// Purpose  : Directed self-checking bench for gshare_branch_predictor
//            (bimodal indexing so PHT entries are PC-selected only).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_branch_predictor;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_lookups;
  int   exp_mis;

  gshare_branch_predictor_if #(.XLEN(32), .BHR_BITS(5), .PERF_BITS(32)) bus ();

  gshare_branch_predictor #(
    .XLEN       (32),
    .INDEX_BITS (5),
    .BHR_BITS   (5),
    .CTR_BITS   (2),
    .HASH_MODE  (0),
    .PERF_BITS  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; track how many non-stalled lookups the DUT should count
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      exp_lookups = 0;
      exp_mis     = 0;
    end else if (!bus.if_stall) begin
      exp_lookups++;
    end
    #1;
  endtask

  task automatic resolve(input logic v, input logic br, input logic jmp, input logic tk,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] pred, input logic [4:0] hist);
    bus.ex_valid        = v;
    bus.ex_is_branch    = br;
    bus.ex_is_jump      = jmp;
    bus.ex_taken        = tk;
    bus.ex_pc           = pc;
    bus.ex_target       = tgt;
    bus.ex_pred_next_pc = pred;
    bus.ex_bhr          = hist;
  endtask

  task automatic idle();
    resolve(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_lookups = 0;
    exp_mis     = 0;
    reset       = 1'b0;
    bus.if_stall = 1'b0;
    bus.if_pc    = 32'h40;
    idle();
    tick();
    tick();

    // Reset state
    check("rst_next_pc",   bus.if_next_pc, 32'h44);
    check("rst_pred",      bus.if_pred_taken, 32'h0);
    check("rst_bhr",       bus.if_bhr, 32'h0);
    check("rst_perf_lk",   bus.perf_lookups, 32'h0);
    check("rst_perf_mis",  bus.perf_mispredicts, 32'h0);
    check("rst_flush",     bus.flush, 32'h0);
    reset = 1'b1;

    // Jump training
    bus.if_pc = 32'h200;
    resolve(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h80, 32'h14, 5'b0);
    #1;
    check("jal_flush",     bus.flush, 32'h1);
    check("jal_redirect",  bus.redirect_pc, 32'h80);
    tick(); exp_mis++;
    idle();
    bus.if_pc = 32'h10; #1;
    check("jal_lookup",    bus.if_next_pc, 32'h80);
    check("jal_pred",      bus.if_pred_taken, 32'h1);
    check("jal_perf_mis",  bus.perf_mispredicts, 32'(exp_mis));
    check("jal_perf_lk",   bus.perf_lookups, 32'(exp_lookups));
    bus.if_pc = 32'h90; #1;
    check("tag_miss",      bus.if_next_pc, 32'h94);
    bus.if_pc = 32'h200;

    // Counter saturation: first taken resolve allocates and moves 01->10
    resolve(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h100, 32'h24, 5'b0);
    #1;
    check("br1_flush",     bus.flush, 32'h1);
    check("br1_redirect",  bus.redirect_pc, 32'h100);
    tick(); exp_mis++;
    idle();
    bus.if_pc = 32'h20; #1;
    check("br1_lookup",    bus.if_next_pc, 32'h100);
    bus.if_pc = 32'h200;
    resolve(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h100, 32'h100, 5'b0);
    #1;
    check("br2_flush",     bus.flush, 32'h0);
    tick(); tick(); tick();
    // First not-taken: 11->10, still predicted taken
    resolve(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h100, 32'h100, 5'b0);
    #1;
    check("nt1_flush",     bus.flush, 32'h1);
    check("nt1_redirect",  bus.redirect_pc, 32'h24);
    tick(); exp_mis++;
    idle();
    bus.if_pc = 32'h20; #1;
    check("nt1_lookup",    bus.if_next_pc, 32'h100);
    bus.if_pc = 32'h200;
    // Second not-taken: 10->01, now predicts fall-through
    resolve(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h100, 32'h100, 5'b0);
    tick(); exp_mis++;
    idle();
    bus.if_pc = 32'h20; #1;
    check("nt2_lookup",    bus.if_next_pc, 32'h24);
    check("nt2_pred",      bus.if_pred_taken, 32'h0);
    bus.if_pc = 32'h200;
    // Two more not-taken pin the counter at 00; one taken must give only 01
    resolve(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h100, 32'h24, 5'b0);
    #1;
    check("nt3_flush",     bus.flush, 32'h0);
    tick(); tick();
    resolve(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h100, 32'h24, 5'b0);
    tick(); exp_mis++;
    idle();
    bus.if_pc = 32'h20; #1;
    check("floor_lookup",  bus.if_next_pc, 32'h24);
    check("floor_bhr",     bus.if_bhr, 32'h01);

    // History recovery overrides the same-cycle speculative shift at 0x20
    resolve(1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h300, 32'h34, 5'b00010);
    #1;
    check("rec_flush",     bus.flush, 32'h1);
    tick(); exp_mis++;
    idle(); #1;
    check("rec_bhr",       bus.if_bhr, 32'h05);
    // Speculative shifts: 0x20 predicts not-taken, 0x30 predicts taken
    tick();
    check("spec0_bhr",     bus.if_bhr, 32'h0A);
    bus.if_pc = 32'h30; #1;
    check("spec1_lookup",  bus.if_next_pc, 32'h300);
    tick();
    check("spec1_bhr",     bus.if_bhr, 32'h15);

    // Stall on a hitting conditional branch
    bus.if_stall = 1'b1;
    tick(); tick(); tick();
    check("stall_bhr",     bus.if_bhr, 32'h15);
    check("stall_perf_lk", bus.perf_lookups, 32'(exp_lookups));
    bus.if_stall = 1'b0;

    // Same-index lookup and retrain: lookup still sees the old target
    bus.if_pc = 32'h10;
    resolve(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h90, 32'h80, 5'b10101);
    #1;
    check("rbw_old",       bus.if_next_pc, 32'h80);
    check("rbw_redirect",  bus.redirect_pc, 32'h90);
    tick(); exp_mis++;
    idle(); #1;
    check("rbw_new",       bus.if_next_pc, 32'h90);
    check("rbw_bhr",       bus.if_bhr, 32'h15);

    // Bubble resolve must not flush or train
    bus.if_pc = 32'h200;
    resolve(1'b0, 1'b1, 1'b0, 1'b1, 32'h50, 32'h500, 32'h54, 5'b0);
    #1;
    check("bub_flush",     bus.flush, 32'h0);
    tick();
    idle();
    bus.if_pc = 32'h50; #1;
    check("bub_lookup",    bus.if_next_pc, 32'h54);
    check("bub_perf_mis",  bus.perf_mispredicts, 32'(exp_mis));
    check("bub_perf_lk",   bus.perf_lookups, 32'(exp_lookups));

    // Mid-run reset with a pending jump resolve
    reset = 1'b0;
    resolve(1'b1, 1'b0, 1'b1, 1'b0, 32'h60, 32'h600, 32'h64, 5'b0);
    tick();
    reset = 1'b1;
    idle();
    bus.if_pc = 32'h10; #1;
    check("mrst_jal",      bus.if_next_pc, 32'h14);
    check("mrst_pred",     bus.if_pred_taken, 32'h0);
    bus.if_pc = 32'h20; #1;
    check("mrst_br",       bus.if_next_pc, 32'h24);
    bus.if_pc = 32'h60; #1;
    check("mrst_pending",  bus.if_next_pc, 32'h64);
    check("mrst_bhr",      bus.if_bhr, 32'h0);
    check("mrst_perf_lk",  bus.perf_lookups, 32'(exp_lookups));
    check("mrst_perf_mis", bus.perf_mispredicts, 32'(exp_mis));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
